// File: rtl/string_accel_engine.sv
// string.h accelerator: compare, toupper, tolower, reverse, windowed search, strlen and char-count
// on two NUM_CHARS-byte operands under a go/done handshake. STR_ACCEL_ICASE_EN adds ops 8 and 12.
module string_accel_engine #(
   parameter int NUM_CHARS = 8,
   parameter int LEN_W     = $clog2(NUM_CHARS + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      go,
   input  logic [3:0]                index,
   input  logic [LEN_W-1:0]          length,
   input  logic [0:NUM_CHARS-1][7:0] A,
   input  logic [0:NUM_CHARS-1][7:0] B,
   output logic                      done,
   output logic                      busy,
   output logic                      error,
   output logic [0:NUM_CHARS-1][7:0] Result
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_SCAN   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(NUM_CHARS);

   // Integer results sit right-aligned in the last byte.
   function automatic logic [0:NUM_CHARS-1][7:0] int_res(input logic [LEN_W-1:0] v);
      int_res                = '0;
      int_res[NUM_CHARS-1]   = {{(8-LEN_W){1'b0}}, v};
   endfunction

   state_t                      state_r, state_nxt_s;
   logic [0:NUM_CHARS-1][7:0]   a_r, b_r, result_r;
   logic [0:NUM_CHARS-1][7:0]   a_cmp_s, b_cmp_s, a_win_s, a_full_rev_s, a_rev_s;
   logic [0:NUM_CHARS-1][7:0]   up_s, lo_s, rv_s, exec_res_s;
   logic [3:0]                  op_r;
   logic [LEN_W-1:0]            len_r, pos_r, len_in_s, slen_s, cnt_s;
   logic [NUM_CHARS-1:0]        in_len_s;
   logic                        op_valid_s, op_search_s, win_match_s, last_pos_s, eq_s;
   logic                        done_r, busy_r, error_r;

   assign len_in_s    = (length > LEN_MAX) ? LEN_MAX : length;
   assign op_search_s = (op_r[2:0] == 3'd4);
   assign last_pos_s  = (pos_r == (LEN_MAX - len_r));

`ifdef STR_ACCEL_ICASE_EN
   function automatic logic [7:0] fold_lc(input logic [7:0] c);
      fold_lc = ((c >= 8'h41) && (c <= 8'h5A)) ? (c + 8'h20) : c;
   endfunction

   // Fold both operands to lowercase for the case-insensitive variants (index[3]=1).
   always_comb begin
      a_cmp_s = a_r;
      b_cmp_s = b_r;
      for (int i = 0; i < NUM_CHARS; i++) begin
         a_cmp_s[i] = op_r[3] ? fold_lc(a_r[i]) : a_r[i];
         b_cmp_s[i] = op_r[3] ? fold_lc(b_r[i]) : b_r[i];
      end
   end
`else
   assign a_cmp_s = a_r;
   assign b_cmp_s = b_r;
`endif

   // Valid op decode.
   always_comb begin
      op_valid_s = 1'b0;
      case (op_r)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: op_valid_s = 1'b1;
`ifdef STR_ACCEL_ICASE_EN
         4'd8, 4'd12:                              op_valid_s = 1'b1;
`endif
         default:                                  op_valid_s = 1'b0;
      endcase
   end

   // Search window starts at byte pos_r; reverse is a full reverse shifted so A[L-1] lands at byte 0.
   assign a_win_s = a_cmp_s << {pos_r, 3'b000};
   assign a_rev_s = a_full_rev_s << {LEN_MAX - len_r, 3'b000};

   // Per-byte datapath for all single-cycle ops and the search window.
   always_comb begin
      eq_s        = 1'b1;
      win_match_s = 1'b1;
      cnt_s       = '0;
      slen_s      = LEN_MAX;
      in_len_s    = '0;
      a_full_rev_s = a_r;
      up_s        = a_r;
      lo_s        = a_r;
      rv_s        = a_r;
      for (int i = 0; i < NUM_CHARS; i++) begin
         in_len_s[i]     = (i < int'(len_r));
         a_full_rev_s[i] = a_r[NUM_CHARS-1-i];
      end
      for (int i = 0; i < NUM_CHARS; i++) begin
         eq_s        = eq_s & ~(in_len_s[i] & (a_cmp_s[i] != b_cmp_s[i]));
         win_match_s = win_match_s & ~(in_len_s[i] & (a_win_s[i] != b_cmp_s[i]));
         cnt_s       = cnt_s + ((in_len_s[i] && (a_r[i] == b_r[0])) ? LEN_W'(1) : LEN_W'(0));
         up_s[i]     = (in_len_s[i] && (a_r[i] >= 8'h61) && (a_r[i] <= 8'h7A)) ? (a_r[i] - 8'h20) : a_r[i];
         lo_s[i]     = (in_len_s[i] && (a_r[i] >= 8'h41) && (a_r[i] <= 8'h5A)) ? (a_r[i] + 8'h20) : a_r[i];
         rv_s[i]     = in_len_s[i] ? a_rev_s[i] : a_r[i];
      end
      for (int i = NUM_CHARS - 1; i >= 0; i--) begin
         slen_s = (a_r[i] == 8'h00) ? LEN_W'(i) : slen_s;
      end
   end

   // Result select for the single-cycle ops.
   always_comb begin
      exec_res_s = '0;
      case (op_r[2:0])
         3'd0:    exec_res_s = int_res({{(LEN_W-1){1'b0}}, eq_s});
         3'd1:    exec_res_s = up_s;
         3'd2:    exec_res_s = lo_s;
         3'd3:    exec_res_s = rv_s;
         3'd5:    exec_res_s = int_res(slen_s);
         3'd6:    exec_res_s = int_res(cnt_s);
         default: exec_res_s = '0;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (go) state_nxt_s = S_DECODE;
            else    state_nxt_s = S_IDLE;
         end
         S_DECODE: begin
            if (!op_valid_s)      state_nxt_s = S_DONE;
            else if (op_search_s) state_nxt_s = S_SCAN;
            else                  state_nxt_s = S_EXEC;
         end
         S_EXEC:  state_nxt_s = S_DONE;
         S_SCAN: begin
            if (win_match_s || last_pos_s) state_nxt_s = S_DONE;
            else                            state_nxt_s = S_SCAN;
         end
         S_DONE: begin
            if (!go) state_nxt_s = S_IDLE;
            else     state_nxt_s = S_DONE;
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // State, operand capture, registered outputs and result update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= S_IDLE;
         a_r      <= '0;
         b_r      <= '0;
         op_r     <= 4'd0;
         len_r    <= '0;
         pos_r    <= '0;
         result_r <= '0;
         done_r   <= 1'b0;
         busy_r   <= 1'b0;
         error_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         done_r  <= (state_nxt_s == S_DONE);
         busy_r  <= (state_nxt_s == S_DECODE) || (state_nxt_s == S_EXEC) || (state_nxt_s == S_SCAN);
         case (state_r)
            S_IDLE: begin
               if (go) begin
                  a_r      <= A;
                  b_r      <= B;
                  op_r     <= index;
                  len_r    <= len_in_s;
                  pos_r    <= '0;
                  result_r <= '0;
                  error_r  <= 1'b0;
               end
            end
            S_DECODE: error_r  <= ~op_valid_s;
            S_EXEC:   result_r <= exec_res_s;
            S_SCAN: begin
               if (win_match_s)     result_r <= int_res(pos_r);
               else if (last_pos_s) result_r <= int_res('0) | {{(8*NUM_CHARS-8){1'b0}}, 8'hFF};
               else                 pos_r    <= pos_r + LEN_W'(1);
            end
            default: result_r <= result_r;
         endcase
      end
   end

   assign done   = done_r;
   assign busy   = busy_r;
   assign error  = error_r;
   assign Result = result_r;

endmodule

// File: tb/tb_string_accel_engine.sv
// Scoreboard bench for string_accel_engine (NUM_CHARS=8): expected results are queued at go
// and popped when done is seen; latency, hold and reset behaviour are checked inline.
module tb_string_accel_engine;
   localparam int N  = 8;
   localparam int LW = $clog2(N + 1);

   logic                clk = 1'b0;
   logic                reset, go;
   logic [3:0]          index;
   logic [LW-1:0]       length;
   logic [0:N-1][7:0]   A, B, Result;
   logic                done, busy, error;

   typedef struct {
      logic [8*N-1:0] res;
      logic           err;
      int             lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   string_accel_engine #(.NUM_CHARS(N)) dut (
      .clk(clk), .reset(reset), .go(go), .index(index), .length(length),
      .A(A), .B(B), .done(done), .busy(busy), .error(error), .Result(Result)
   );

   always #5 clk = ~clk;

   task automatic run_op(input logic [3:0] idx, input logic [LW-1:0] len,
                         input logic [8*N-1:0] a, input logic [8*N-1:0] b,
                         input logic [8*N-1:0] exp_res, input logic exp_err, input int exp_lat,
                         input bit hold, input string name);
      exp_t e;
      int   cyc;
      bit   seen;
      sb.push_back('{res: exp_res, err: exp_err, lat: exp_lat});
      @(negedge clk);
      go = 1'b1; index = idx; length = len; A = a; B = b;
      @(posedge clk); #1;
      if (!hold) go = 1'b0;
      A = ~a; B = ~b; index = idx ^ 4'h5; length = ~len;
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         bad++; $display("FAIL %s accept: busy=%b done=%b want busy=1 done=0", name, busy, done);
      end
      total++;
      if (Result !== '0) begin
         bad++; $display("FAIL %s clear_on_accept: Result=%h want 0", name, Result);
      end
      seen = 1'b0;
      for (cyc = 1; cyc <= 40; cyc++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      e = sb.pop_front();
      total++;
      if (!seen) begin
         bad++; $display("FAIL %s timeout: done not seen in 40 cycles, want latency %0d", name, e.lat);
      end else begin
         total++;
         if (cyc != e.lat) begin
            bad++; $display("FAIL %s latency: got %0d want %0d", name, cyc, e.lat);
         end
         total++;
         if (Result !== e.res) begin
            bad++; $display("FAIL %s result: got %h want %h", name, Result, e.res);
         end
         total++;
         if (error !== e.err || busy !== 1'b0) begin
            bad++; $display("FAIL %s flags: error=%b busy=%b want error=%b busy=0", name, error, busy, e.err);
         end
      end
      if (hold) begin
         repeat (3) begin
            @(posedge clk); #1;
            total++;
            if (done !== 1'b1 || busy !== 1'b0 || Result !== e.res || error !== e.err) begin
               bad++; $display("FAIL %s hold: done=%b busy=%b Result=%h want done=1 busy=0 Result=%h",
                               name, done, busy, Result, e.res);
            end
         end
         @(negedge clk); go = 1'b0;
         @(posedge clk); #1;
         total++;
         if (done !== 1'b0) begin
            bad++; $display("FAIL %s release: done=%b want 0", name, done);
         end
      end else begin
         @(posedge clk); #1;
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || Result !== e.res) begin
            bad++; $display("FAIL %s pulse: done=%b busy=%b Result=%h want done=0 busy=0 Result=%h",
                            name, done, busy, Result, e.res);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; go = 1'b0; index = 4'd0; length = '0; A = '0; B = '0;
      #12;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || error !== 1'b0 || Result !== '0) begin
         bad++; $display("FAIL reset: done=%b busy=%b error=%b Result=%h want all 0", done, busy, error, Result);
      end
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_case_ops();
      run_op(4'd1, 4'd8, "abcXYZ1!", "00000000", "ABCXYZ1!", 1'b0, 3, 1'b0, "toupper");
      run_op(4'd2, 4'd5, "HeLLo W!", "00000000", "hello W!", 1'b0, 3, 1'b0, "tolower_L5");
      run_op(4'd3, 4'd5, "abcdefgh", "00000000", "edcbafgh", 1'b0, 3, 1'b0, "reverse_L5");
      run_op(4'd3, 4'd8, "abcdefgh", "00000000", "hgfedcba", 1'b0, 3, 1'b0, "reverse_L8");
   endtask

   task automatic test_compare();
      run_op(4'd0, 4'd3, "abcd0000", "abcx0000", 64'd1, 1'b0, 3, 1'b0, "cmp_L3");
      run_op(4'd0, 4'd4, "abcd0000", "abcx0000", 64'd0, 1'b0, 3, 1'b0, "cmp_L4");
      run_op(4'd0, 4'd0, "abcd0000", "abcx0000", 64'd1, 1'b0, 3, 1'b0, "cmp_L0");
`ifdef STR_ACCEL_ICASE_EN
      run_op(4'd8, 4'd4, "ABCD0000", "abcd0000", 64'd1, 1'b0, 3, 1'b0, "cmp_icase");
`else
      run_op(4'd8, 4'd4, "ABCD0000", "abcd0000", 64'd0, 1'b1, 2, 1'b0, "cmp_icase_off");
`endif
   endtask

   task automatic test_search();
      run_op(4'd4, 4'd2, "hello wo", {"lo", 48'h0}, 64'd3, 1'b0, 6, 1'b0, "search_hit");
      run_op(4'd4, 4'd2, "abcdefgh", {"zz", 48'h0}, 64'hFF, 1'b0, 9, 1'b0, "search_miss");
      run_op(4'd4, 4'd2, "abcdefgh", {"gh", 48'h0}, 64'd6, 1'b0, 9, 1'b0, "search_last");
      run_op(4'd4, 4'd8, "abcdefgh", "abcdefgh", 64'd0, 1'b0, 3, 1'b0, "search_full_hit");
      run_op(4'd4, 4'd8, "abcdefgh", "abcdefgX", 64'hFF, 1'b0, 3, 1'b0, "search_full_miss");
      run_op(4'd4, 4'd0, "abcdefgh", "zzzzzzzz", 64'd0, 1'b0, 3, 1'b0, "search_L0");
   endtask

   task automatic test_strlen_count();
      run_op(4'd5, 4'd3, {"hi", 48'h0}, "00000000", 64'd2, 1'b0, 3, 1'b0, "strlen_2");
      run_op(4'd5, 4'd0, "abcdefgh", "00000000", 64'd8, 1'b0, 3, 1'b0, "strlen_none");
      run_op(4'd6, 4'd8, {"banana", 16'h0}, {"a", 56'h0}, 64'd3, 1'b0, 3, 1'b0, "count_L8");
      run_op(4'd6, 4'd3, {"banana", 16'h0}, {"a", 56'h0}, 64'd1, 1'b0, 3, 1'b0, "count_L3");
   endtask

   task automatic test_clamp();
      run_op(4'd1, 4'd15, "abcdefgh", "00000000", "ABCDEFGH", 1'b0, 3, 1'b0, "clamp_toupper");
      run_op(4'd6, 4'd12, "aaaaaaaa", {"a", 56'h0}, 64'd8, 1'b0, 3, 1'b0, "clamp_count");
   endtask

   task automatic test_invalid();
      run_op(4'd9, 4'd4, "abcdefgh", "abcdefgh", 64'd0, 1'b1, 2, 1'b0, "invalid_9");
      run_op(4'd7, 4'd4, "abcdefgh", "abcdefgh", 64'd0, 1'b1, 2, 1'b1, "invalid_7_hold");
      run_op(4'd0, 4'd4, "abcdefgh", "abcdefgh", 64'd1, 1'b0, 3, 1'b0, "error_clears");
   endtask

   task automatic test_go_hold();
      run_op(4'd1, 4'd8, "xyz12abc", "00000000", "XYZ12ABC", 1'b0, 3, 1'b1, "hold_toupper");
      run_op(4'd4, 4'd2, "hello wo", {"wo", 48'h0}, 64'd6, 1'b0, 9, 1'b1, "hold_search");
   endtask

   task automatic test_reset_mid_scan();
      @(negedge clk);
      go = 1'b1; index = 4'd4; length = 4'd2; A = "abcdefgh"; B = {"zz", 48'h0};
      @(posedge clk); #1;
      go = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         bad++; $display("FAIL midscan_busy: busy=%b done=%b want busy=1 done=0", busy, done);
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || error !== 1'b0 || Result !== '0) begin
         bad++; $display("FAIL midscan_reset: done=%b busy=%b error=%b Result=%h want all 0",
                         done, busy, error, Result);
      end
      @(negedge clk); reset = 1'b1;
      run_op(4'd4, 4'd2, "hello wo", {"lo", 48'h0}, 64'd3, 1'b0, 6, 1'b0, "after_reset_search");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         run_op(4'd5, 4'd0, {"abcdefgh"} & ~(64'hFF << (8 * (7 - i))), "00000000",
                64'(i), 1'b0, 3, 1'b0, "b2b_strlen");
      end
   endtask

   initial begin
      test_reset();
      test_case_ops();
      test_compare();
      test_search();
      test_strlen_count();
      test_clamp();
      test_invalid();
      test_go_hold();
      test_reset_mid_scan();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
